// File: rtl/throw_ctrl.sv
// Throw controller: debounced buttons, ready handshake and charge/fire FSM.
// Optional THROW_POWER_PINGPONG_EN makes power ramp as a triangle wave.

module throw_ctrl_debounce #(
  parameter int unsigned CYCLES = 650_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;

endmodule

module throw_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 650_000,
  parameter int unsigned POWER_STEP_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ready,
  input  logic       btn_throw,
  input  logic       remote_ready,
  input  logic       player_id,
  output logic       player1_ready,
  output logic       player2_ready,
  output logic [4:0] power,
  output logic       throw_flag
);

  localparam int unsigned SW =
    (POWER_STEP_CYCLES > 1) ? $clog2(POWER_STEP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CHARGE,
    FIRE
  } state_e;

  logic ready_lvl;
  logic throw_lvl;
  logic ready_prev_q;
  logic throw_prev_q;
  logic ready_rise;
  logic throw_rise;
  logic throw_fall;

  state_e        state_q;
  logic          local_ready_q;
  logic [4:0]    power_q;
  logic [4:0]    power_d;
  logic          flag_q;
  logic [SW-1:0] step_q;
  logic          step_tick;

`ifdef THROW_POWER_PINGPONG_EN
  logic dir_q;
  logic dir_d;
`endif

  throw_ctrl_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db_ready (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_ready),
    .level_o (ready_lvl)
  );

  throw_ctrl_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db_throw (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_throw),
    .level_o (throw_lvl)
  );

  assign ready_rise = ready_lvl & ~ready_prev_q;
  assign throw_rise = throw_lvl & ~throw_prev_q;
  assign throw_fall = ~throw_lvl & throw_prev_q;
  assign step_tick  = (step_q == SW'(POWER_STEP_CYCLES - 1));

  // Next power value on a step tick.
  always_comb begin
`ifdef THROW_POWER_PINGPONG_EN
    power_d = power_q;
    dir_d   = dir_q;
    if (!dir_q) begin
      if (power_q == 5'd31) begin
        power_d = 5'd30;
        dir_d   = 1'b1;
      end else begin
        power_d = power_q + 5'd1;
      end
    end else begin
      if (power_q == 5'd0) begin
        power_d = 5'd1;
        dir_d   = 1'b0;
      end else begin
        power_d = power_q - 5'd1;
      end
    end
`else
    power_d = power_q;
    if (power_q != 5'd31) begin
      power_d = power_q + 5'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      local_ready_q <= 1'b0;
      power_q       <= '0;
      flag_q        <= 1'b0;
      step_q        <= '0;
      ready_prev_q  <= 1'b0;
      throw_prev_q  <= 1'b0;
`ifdef THROW_POWER_PINGPONG_EN
      dir_q         <= 1'b0;
`endif
    end else begin
      ready_prev_q <= ready_lvl;
      throw_prev_q <= throw_lvl;
      flag_q       <= 1'b0;
      if (ready_rise) begin
        local_ready_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (local_ready_q && remote_ready) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (!remote_ready) begin
            state_q <= IDLE;
            power_q <= '0;
          end else if (throw_rise) begin
            state_q <= CHARGE;
            power_q <= '0;
            step_q  <= '0;
`ifdef THROW_POWER_PINGPONG_EN
            dir_q   <= 1'b0;
`endif
          end
        end
        CHARGE: begin
          // Abort beats release, release beats a step tick.
          if (!remote_ready) begin
            state_q <= IDLE;
            power_q <= '0;
            step_q  <= '0;
          end else if (throw_fall) begin
            state_q <= FIRE;
            flag_q  <= 1'b1;
          end else if (throw_lvl) begin
            if (step_tick) begin
              step_q  <= '0;
              power_q <= power_d;
`ifdef THROW_POWER_PINGPONG_EN
              dir_q   <= dir_d;
`endif
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
        FIRE: begin
          state_q <= ARMED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign player1_ready = player_id ? remote_ready : local_ready_q;
  assign player2_ready = player_id ? local_ready_q : remote_ready;
  assign power         = power_q;
  assign throw_flag    = flag_q;

endmodule

// File: tb/tb_throw_ctrl.sv
// Directed + randomized bench for throw_ctrl with DEBOUNCE=4, STEP=2.
// Power expectations come from a step-count model of the charge phase.

module tb_throw_ctrl;

  localparam int DB   = 4;
  localparam int STEP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_ready;
  logic       btn_throw;
  logic       remote_ready;
  logic       player_id;
  logic       player1_ready;
  logic       player2_ready;
  logic [4:0] power;
  logic       throw_flag;

  int errors   = 0;
  int checks   = 0;
  int flag_cnt = 0;

  always #5 clk = ~clk;

  throw_ctrl #(
    .DEBOUNCE_CYCLES   (DB),
    .POWER_STEP_CYCLES (STEP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_ready     (btn_ready),
    .btn_throw     (btn_throw),
    .remote_ready  (remote_ready),
    .player_id     (player_id),
    .player1_ready (player1_ready),
    .player2_ready (player2_ready),
    .power         (power),
    .throw_flag    (throw_flag)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (throw_flag) flag_cnt++;
    end
  endtask

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // A raw press of h cycles (h >= DB) gives h debounced-high cycles:
  // one enters CHARGE, the other h-1 accumulate steps.
  function automatic int model_power(input int h);
    int k;
    int t;
    k = (h - 1) / STEP;
`ifdef THROW_POWER_PINGPONG_EN
    t = k % 62;
    return (t <= 31) ? t : 62 - t;
`else
    t = 0;
    return (k > 31) ? 31 + t : k;
`endif
  endfunction

  task automatic do_throw(input string tag, input int h);
    int f0;
    f0 = flag_cnt;
    btn_throw = 1'b1;
    tick(h);
    btn_throw = 1'b0;
    tick(20);
    check({tag, "_power"}, power, model_power(h));
    check({tag, "_flag"}, flag_cnt - f0, 1);
  endtask

  initial begin
    int f0;
    int h;
    bit found;
    rst_n        = 1'b0;
    btn_ready    = 1'b0;
    btn_throw    = 1'b0;
    remote_ready = 1'b0;
    player_id    = 1'b0;
    tick(3);
    check("rst_p1", player1_ready, 0);
    check("rst_p2", player2_ready, 0);
    check("rst_power", power, 0);
    check("rst_flag", throw_flag, 0);

    rst_n = 1'b1;
    btn_ready = 1'b1;
    tick(3);
    btn_ready = 1'b0;
    tick(20);
    check("short_p1", player1_ready, 0);
    check("short_p2", player2_ready, 0);

    btn_ready = 1'b1;
    tick(10);
    btn_ready = 1'b0;
    tick(20);
    check("long_p1", player1_ready, 1);
    check("long_p2", player2_ready, 0);
    player_id = 1'b1;
    tick(1);
    check("swap_p1", player1_ready, 0);
    check("swap_p2", player2_ready, 1);
    player_id = 1'b0;
    remote_ready = 1'b1;
    tick(5);
    check("both_p2", player2_ready, 1);

    flag_cnt = 0;
    do_throw("h15", 15);
    check("h15_seven", power, 7);
    tick(10);
    check("hold_power", power, 7);
    do_throw("h16_coincide", 16);
    do_throw("h4_min", 4);
    do_throw("h100", 100);
    for (int i = 0; i < 6; i++) begin
      h = $urandom_range(4, 140);
      do_throw($sformatf("rand%0d_h%0d", i, h), h);
    end

    f0 = flag_cnt;
    btn_throw = 1'b1;
    tick(20);
    remote_ready = 1'b0;
    tick(2);
    check("drop_power", power, 0);
    btn_throw = 1'b0;
    tick(20);
    check("drop_noflag", flag_cnt - f0, 0);
    remote_ready = 1'b1;
    tick(5);
    do_throw("after_drop", 21);

    f0 = flag_cnt;
    found = 1'b0;
    btn_throw = 1'b1;
    for (int i = 0; i < 300 && !found; i++) begin
      tick(1);
      if (power == 5'd5) found = 1'b1;
    end
    check("reach_power5", int'(found), 1);
    rst_n = 1'b0;
    remote_ready = 1'b0;
    tick(1);
    check("midrst_power", power, 0);
    check("midrst_p1", player1_ready, 0);
    check("midrst_p2", player2_ready, 0);
    check("midrst_flag", throw_flag, 0);
    rst_n = 1'b1;
    btn_throw = 1'b0;
    remote_ready = 1'b1;
    tick(30);
    check("midrst_noflag", flag_cnt - f0, 0);
    check("midrst_p1_clr", player1_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
